// File: rtl/fft_pkg.sv
// Shared types and size helpers for the in-place radix-2 FFT sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MUL  = 2'd2,
        WR   = 2'd3
    } state_t;

    function automatic int pts(input int log2_pts);
        return 1 << log2_pts;
    endfunction

    function automatic int half_size(input int stage);
        return 1 << stage;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly addressing: (stage, butterfly) -> top/bottom RAM addresses and twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_PTS = 3,
    parameter int SW       = 2
) (
    input  logic [SW-1:0]       s,
    input  logic [LOG2_PTS-2:0] k,
    output logic [LOG2_PTS-1:0] addr_a,
    output logic [LOG2_PTS-1:0] addr_b,
    output logic [LOG2_PTS-2:0] tw_addr
);
    localparam int AW = LOG2_PTS;
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] half;
    logic [AW-1:0] m;
    logic [AW-1:0] j;
    logic [AW-1:0] a;
    logic [SW-1:0] tw_shift;

    always_comb begin
        half     = AW'(half_size(int'(s)));
        m        = {1'b0, k} & (half - ONE);
        j        = {1'b0, k} >> s;
        // group j starts at j * 2^(s+1); shifting twice avoids overflowing the s width
        a        = ((j << s) << 1) | m;
        tw_shift = SW'(AW - 1) - s;
        addr_a   = a;
        addr_b   = a + half;
        tw_addr  = (AW-1)'(m << tw_shift);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences an in-place radix-2 DIT FFT over an external RAM, one butterfly per 3 cycles (RD, MUL, WR).
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N        = 16,
    parameter int Q        = 8,
    parameter int LOG2_PTS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [LOG2_PTS-1:0] rd_addr_a,
    output logic [LOG2_PTS-1:0] rd_addr_b,
    input  logic [N-1:0]        rd_a_re,
    input  logic [N-1:0]        rd_a_im,
    input  logic [N-1:0]        rd_b_re,
    input  logic [N-1:0]        rd_b_im,
    output logic [LOG2_PTS-2:0] tw_addr,
    input  logic [N-1:0]        tw_re,
    input  logic [N-1:0]        tw_im,
    output logic [N-1:0]        mul_x1_re,
    output logic [N-1:0]        mul_x1_im,
    output logic [N-1:0]        mul_x2_re,
    output logic [N-1:0]        mul_x2_im,
    input  logic [N-1:0]        mul_z_re,
    input  logic [N-1:0]        mul_z_im,
    output logic                wr_en,
    output logic [LOG2_PTS-1:0] wr_addr_a,
    output logic [LOG2_PTS-1:0] wr_addr_b,
    output logic [N-1:0]        wr_a_re,
    output logic [N-1:0]        wr_a_im,
    output logic [N-1:0]        wr_b_re,
    output logic [N-1:0]        wr_b_im
);
    localparam int SW = (LOG2_PTS > 1) ? $clog2(LOG2_PTS) : 1;
    localparam int KW = $clog2(pts(LOG2_PTS) / 2);
    localparam int AW = LOG2_PTS;

    generate
        if (Q >= N) begin : g_q_check
            $error("fft_stage_sequencer: Q must be smaller than N");
        end
    endgenerate

    state_t state_reg, state_next;
    logic [SW-1:0] s_reg, s_next;
    logic [KW-1:0] k_reg, k_next;

    logic          last_k;
    logic          last_bfly;

    logic [AW-1:0] gen_addr_a;
    logic [AW-1:0] gen_addr_b;
    logic [AW-2:0] gen_tw_addr;

    logic          busy_reg;
    logic          done_reg;
    logic          rd_en_reg;
    logic          wr_en_reg;
    logic [AW-1:0] rd_addr_a_reg;
    logic [AW-1:0] rd_addr_b_reg;
    logic [AW-2:0] tw_addr_reg;
    logic [AW-1:0] wr_addr_a_reg;
    logic [AW-1:0] wr_addr_b_reg;

    assign last_k    = &k_reg;
    assign last_bfly = last_k && (s_reg == SW'(LOG2_PTS - 1));

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                s_next = '0;
                k_next = '0;
                if (start) begin
                    state_next = RD;
                end
            end
            RD:  state_next = MUL;
            MUL: state_next = WR;
            WR: begin
                if (last_bfly) begin
                    state_next = IDLE;
                    s_next     = '0;
                    k_next     = '0;
                end else begin
                    state_next = RD;
                    k_next     = k_reg + KW'(1);
                    if (last_k) begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Addresses come from the upcoming counter values so they are registered on entry to RD.
    fft_addr_gen #(
        .LOG2_PTS(LOG2_PTS),
        .SW      (SW)
    ) u_addr_gen (
        .s      (s_next),
        .k      (k_next),
        .addr_a (gen_addr_a),
        .addr_b (gen_addr_b),
        .tw_addr(gen_tw_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            k_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_en_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            rd_addr_a_reg <= '0;
            rd_addr_b_reg <= '0;
            tw_addr_reg   <= '0;
            wr_addr_a_reg <= '0;
            wr_addr_b_reg <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            k_reg     <= k_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_reg == WR) && (state_next == IDLE);
            rd_en_reg <= (state_next == RD);
            wr_en_reg <= (state_next == WR);
            if (state_next == RD) begin
                rd_addr_a_reg <= gen_addr_a;
                rd_addr_b_reg <= gen_addr_b;
                tw_addr_reg   <= gen_tw_addr;
            end
            if (state_reg == MUL) begin
                wr_addr_a_reg <= rd_addr_a_reg;
                wr_addr_b_reg <= rd_addr_b_reg;
            end
        end
    end

    // Operands only reach the shared multiplier while this sequencer owns it.
    assign mul_x1_re = (state_reg == MUL) ? rd_b_re : '0;
    assign mul_x1_im = (state_reg == MUL) ? rd_b_im : '0;
    assign mul_x2_re = (state_reg == MUL) ? tw_re   : '0;
    assign mul_x2_im = (state_reg == MUL) ? tw_im   : '0;

    // Lane 0 is the real part, lane 1 the imaginary part.
    logic [N-1:0] a_lane   [2];
    logic [N-1:0] p_lane   [2];
    logic [N-1:0] res_a_reg[2];
    logic [N-1:0] res_b_reg[2];

    assign a_lane[0] = rd_a_re;
    assign a_lane[1] = rd_a_im;
    assign p_lane[0] = mul_z_re;
    assign p_lane[1] = mul_z_im;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [N:0] sum_full;
            logic [N:0] dif_full;

            // N+1-bit sums cannot overflow; dropping bit 0 is the per-stage floor halving.
            assign sum_full = {a_lane[gi][N-1], a_lane[gi]} + {p_lane[gi][N-1], p_lane[gi]};
            assign dif_full = {a_lane[gi][N-1], a_lane[gi]} - {p_lane[gi][N-1], p_lane[gi]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_a_reg[gi] <= '0;
                    res_b_reg[gi] <= '0;
                end else if (state_reg == MUL) begin
                    res_a_reg[gi] <= N'(sum_full >> 1);
                    res_b_reg[gi] <= N'(dif_full >> 1);
                end
            end
        end
    endgenerate

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign rd_en     = rd_en_reg;
    assign rd_addr_a = rd_addr_a_reg;
    assign rd_addr_b = rd_addr_b_reg;
    assign tw_addr   = tw_addr_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr_a = wr_addr_a_reg;
    assign wr_addr_b = wr_addr_b_reg;
    assign wr_a_re   = res_a_reg[0];
    assign wr_a_im   = res_a_reg[1];
    assign wr_b_re   = res_b_reg[0];
    assign wr_b_im   = res_b_reg[1];

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

- Sequences a complete in-place radix-2 decimation-in-time FFT over an external sample RAM.
- Drives one shared combinational `complex_multiplier` instance, one butterfly at a time.
- For each butterfly it generates the RAM read and write addresses and the twiddle ROM address, routes operands to the multiplier, and computes the scaled add/subtract.
- Sits between the sample RAM / twiddle ROM and the FFT datapath; a host starts it and waits for `done`.

## Interface
- `N`, 16, sample/twiddle word width (signed, Q-format).
- `Q`, 8, fractional bits; the multiplier returns product bits [N+Q-1:Q].
- `LOG2_PTS`, 3, log2 of transform size; PTS = 2^LOG2_PTS.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `busy`  out  1  high from the first RD cycle through the last WR cycle.
- `done`  out  1  one-cycle pulse after the last write.
- `rd_en`  out  1  RAM read strobe; data valid the next cycle.
- `rd_addr_a`, `rd_addr_b`  out  LOG2_PTS  butterfly top/bottom read addresses.
- `rd_a_re`, `rd_a_im`, `rd_b_re`, `rd_b_im`  in  N  RAM read data.
- `tw_addr`  out  LOG2_PTS-1  twiddle ROM address; data valid the next cycle.
- `tw_re`, `tw_im`  in  N  twiddle W^k = exp(-j2πk/PTS), Q-format.
- `mul_x1_re`, `mul_x1_im`, `mul_x2_re`, `mul_x2_im`  out  N  multiplier operands.
- `mul_z_re`, `mul_z_im`  in  N  multiplier product (combinational return).
- `wr_en`  out  1  RAM write strobe; writes both ports in the same cycle.
- `wr_addr_a`, `wr_addr_b`  out  LOG2_PTS  write addresses.
- `wr_a_re`, `wr_a_im`, `wr_b_re`, `wr_b_im`  out  N  butterfly results.

## Operation
- **Input order:** the RAM holds input in bit-reversed order; output is left in natural order, in place.
- **States:** IDLE, RD, MUL, WR.
  - IDLE→RD on `start`.
  - RD→MUL→WR unconditionally.
  - WR→RD if butterflies remain; WR→IDLE after stage LOG2_PTS-1, butterfly PTS/2-1.
- **Counters:** stage s (0..LOG2_PTS-1), butterfly k (0..PTS/2-1).
  - k increments in WR and wraps to 0, at which point s increments.
  - Both counters clear in IDLE.
- **Addressing:**
  - half = 2^s, m = k mod half, j = k >> s.
  - addr_a = j·2^(s+1) + m; addr_b = addr_a + half.
  - tw_addr = m << (LOG2_PTS-1-s).
- **RD:** `rd_en`=1; drive `rd_addr_a`/`rd_addr_b` and `tw_addr`.
- **MUL:**
  - Drive mul_x1 = (rd_b_re, rd_b_im) and mul_x2 = (tw_re, tw_im), both combinationally from the inputs.
  - Register the P = mul_z and A = rd_a values.
  - Outside MUL, the `mul_x*` outputs are 0.
- **WR:** `wr_en`=1, addresses equal to the RD addresses of the same butterfly.
- **Arithmetic:**
  - Sums are formed in N+1 bits: wr_a = (A+P)[N:1], wr_b = (A−P)[N:1].
  - This is an arithmetic divide by 2 (floor) per stage, so the total scale is 1/PTS. There is no saturation.
- **start while busy:** ignored.
- **Reset:** asserting `rst_n` low mid-transform returns to IDLE immediately. A partially processed RAM is left as is.

## Timing
- **Reset values:** every output 0; state IDLE; counters 0.
- **Start:**
  - `start` sampled high at edge t: RD occupies cycle t+1, and `busy` rises at t+1.
  - Each butterfly takes exactly 3 cycles.
- **Completion:**
  - Let S = LOG2_PTS·PTS/2. The last WR cycle is t+3S; `done`=1 and `busy`=0 in cycle t+3S+1 (state IDLE).
  - A `start` in that done cycle is accepted.
- **Registered outputs:** `rd_*`, `tw_addr`, `wr_*`, `busy`, `done`.
- **Combinational outputs:** `mul_x*` only.

## Structure
- **Package `fft_pkg`:** state enum (IDLE, RD, MUL, WR) and a PTS/half-size helper function.
- **Sub-module `fft_addr_gen`:** combinational (s, k) → addr_a, addr_b, tw_addr. Instantiated once; the registered addresses are reused for WR.
- **Butterfly add/sub and scaling:** inline in the sequencer.

## Test plan
- **Impulse, LOG2_PTS=3, Q=8:** x[0]=256, all others 0 → all 8 bins re=32, im=0; `done` exactly 37 cycles after the `start` edge.
- **DC:** all eight samples re=256, im=0 → X[0]=256, all other bins within ±1 LSB of 0.
- **Address trace:**
  - Stage s=1, k=1 → rd_addr_a=1, rd_addr_b=3, tw_addr=2.
  - Stage s=2, k=3 → addr_a=3, addr_b=7, tw_addr=3.
  - Write addresses match read addresses for every butterfly.
- **Protocol:**
  - `start` pulsed while busy → no restart, identical `done` timing.
  - `start` held high through the done cycle → a second transform begins at the next cycle.
- **Reset mid-transform:** drop `rst_n` low in a MUL cycle of stage 1 → all outputs 0 asynchronously; after release, IDLE with no `wr_en` until the next `start`.
- **Overflow/scaling:** A=0x7FFF, B·W=0x7FFF → wr_a=0x7FFF, wr_b=0; A=0x8000, P=0x8000 → wr_a=0x8000.
